// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges add/mul/div results onto the common data bus.
// Each source has a FIFO; one head is granted per cycle, round-robin.
// Optional zero-latency bypass of empty FIFOs: define CDB_ARB_BYPASS_EN.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cdb_add/mul/div_in     per-unit results, qualified by .valid
//   flush                  drops all buffered and same-cycle results
//   cdb_out                granted broadcast, all-zero when idle
//   stall_add/mul/div      issue must not start that unit this cycle
//   overflow               sticky: a result was dropped on a full FIFO
package cdb_pkg;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [5:0]  pd_s;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        valid;
    } cdb_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int PHYS_REG_BITS = 6
) (
    input  logic clk,
    input  logic rst,
    input  cdb_t cdb_add_in,
    input  cdb_t cdb_mul_in,
    input  cdb_t cdb_div_in,
    input  logic flush,
    output cdb_t cdb_out,
    output logic stall_add,
    output logic stall_mul,
    output logic stall_div,
    output logic overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] P1       = PW'(1);
    localparam logic [CW-1:0] C1       = CW'(1);

    cdb_t          mem_q [3][FIFO_DEPTH];
    logic [PW-1:0] head_q [3];
    logic [PW-1:0] head_d [3];
    logic [PW-1:0] tail_q [3];
    logic [PW-1:0] tail_d [3];
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [1:0]    rr_q, rr_d;
    logic          ovf_q, ovf_d;
    cdb_t          in_w [3];
    cdb_t          sel;
    logic [2:0]    has, cand, pop, push, drop, taken;
    logic [1:0]    s1, s2, win;
    logic          gnt, kill;

    assign in_w      = '{cdb_add_in, cdb_mul_in, cdb_div_in};
    assign kill      = rst | flush;
    assign stall_add = cnt_q[0] >= STALL_AT;
    assign stall_mul = cnt_q[1] >= STALL_AT;
    assign stall_div = cnt_q[2] >= STALL_AT;
    assign overflow  = ovf_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            has[i] = cnt_q[i] != '0;
`ifdef CDB_ARB_BYPASS_EN
            cand[i] = has[i] | in_w[i].valid;
`else
            cand[i] = has[i];
`endif
        end
        s1  = rr_q == 2'd2 ? 2'd0 : rr_q + 2'd1;
        s2  = rr_q == 2'd0 ? 2'd2 : rr_q - 2'd1;
        win = cand[rr_q] ? rr_q : cand[s1] ? s1 : s2;
        gnt = |cand & ~kill;
`ifdef CDB_ARB_BYPASS_EN
        // an empty FIFO can only win through its same-cycle input
        sel = has[win] ? mem_q[win][head_q[win]] : in_w[win];
`else
        sel = mem_q[win][head_q[win]];
`endif
        cdb_out = '0;
        if (gnt) begin
            cdb_out       = sel;
            cdb_out.pd_s  = sel.pd_s[PHYS_REG_BITS-1:0];
            cdb_out.valid = 1'b1;
        end
        rr_d  = kill ? 2'd0 : gnt ? (win == 2'd2 ? 2'd0 : win + 2'd1) : rr_q;
        ovf_d = ovf_q;
        for (int i = 0; i < 3; i++) begin
            pop[i]   = gnt && win == 2'(i) && has[i];
            taken[i] = gnt && win == 2'(i) && !has[i];
            // a full FIFO still accepts when its head leaves this cycle
            push[i]  = in_w[i].valid && !kill && !taken[i] && (cnt_q[i] != FULL || pop[i]);
            drop[i]  = in_w[i].valid && !kill && !taken[i] && !push[i];
            ovf_d    = ovf_d | drop[i];
            head_d[i] = kill ? '0 : head_q[i] + (pop[i] ? P1 : '0);
            tail_d[i] = kill ? '0 : tail_q[i] + (push[i] ? P1 : '0);
            cnt_d[i]  = kill ? '0 : cnt_q[i] + (push[i] ? C1 : '0) - (pop[i] ? C1 : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_q  <= 2'd0;
            ovf_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            ovf_q  <= ovf_d;
        end
        for (int i = 0; i < 3; i++)
            if (push[i]) mem_q[i][tail_q[i]] <= in_w[i];
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: random and directed stimulus against a queue-based model.
module tb_cdb_arbiter;
    import cdb_pkg::*;
    localparam int D = 4;
    localparam bit BYP = 1'b0;

    logic clk, rst, flush;
    cdb_t cdb_add_in, cdb_mul_in, cdb_div_in, cdb_out;
    logic stall_add, stall_mul, stall_div, overflow;

    cdb_arbiter #(.FIFO_DEPTH(D), .PHYS_REG_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .cdb_add_in(cdb_add_in), .cdb_mul_in(cdb_mul_in), .cdb_div_in(cdb_div_in),
        .flush(flush), .cdb_out(cdb_out),
        .stall_add(stall_add), .stall_mul(stall_mul), .stall_div(stall_div),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0, n_err = 0, seq = 0, m_rr = 0;
    bit   m_ovf = 1'b0;
    cdb_t mq [3][$];
    cdb_t nil = '0;
    cdb_t last_out, t1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cdb_t mk(input int src, input bit v);
        cdb_t r = '0;
        if (v) begin
            r.rob_idx = 6'($urandom);
            r.pd_s    = 6'($urandom);
            r.rd_s    = 5'($urandom);
            r.rd_v    = {8'(src), 24'(seq)};
            r.valid   = 1'b1;
            seq++;
        end
        return r;
    endfunction

    task automatic step(input cdb_t a, input cdb_t m, input cdb_t d, input bit fl, input bit rs);
        cdb_t       in_v [3];
        cdb_t       exp_o;
        logic [2:0] exp_st;
        bit         taken [3];
        bit         ovf_prev;
        int         win;
        @(negedge clk);
        cdb_add_in = a;
        cdb_mul_in = m;
        cdb_div_in = d;
        flush = fl;
        rst = rs;
        #1;
        in_v = '{a, m, d};
        taken = '{0, 0, 0};
        ovf_prev = m_ovf;
        for (int i = 0; i < 3; i++) exp_st[i] = mq[i].size() >= D - 1;
        exp_o = '0;
        win = -1;
        if (!(fl || rs)) begin
            for (int k = 0; k < 3; k++) begin
                int s = (m_rr + k) % 3;
                if (win < 0 && (mq[s].size() > 0 || (BYP && in_v[s].valid))) win = s;
            end
            if (win >= 0) begin
                if (mq[win].size() > 0) exp_o = mq[win].pop_front();
                else begin
                    exp_o = in_v[win];
                    taken[win] = 1'b1;
                end
                exp_o.valid = 1'b1;
                m_rr = (win + 1) % 3;
            end
            for (int i = 0; i < 3; i++)
                if (in_v[i].valid && !taken[i]) begin
                    if (mq[i].size() < D) mq[i].push_back(in_v[i]);
                    else m_ovf = 1'b1;
                end
        end else begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_rr = 0;
            if (rs) m_ovf = 1'b0;
        end
        last_out = cdb_out;
        check("cdb_out", 64'(cdb_out), 64'(exp_o));
        check("stall", 64'({stall_div, stall_mul, stall_add}), 64'(exp_st));
        check("overflow", 64'(overflow), 64'(ovf_prev));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        cdb_add_in = '0;
        cdb_mul_in = '0;
        cdb_div_in = '0;
        repeat (2) step(nil, nil, nil, 0, 1);
        t1 = '{rob_idx: 6'd5, pd_s: 6'd12, rd_s: 5'd3, rd_v: 32'hDEADBEEF, valid: 1'b1};
        step(t1, nil, nil, 0, 0);
        step(nil, nil, nil, 0, 0);
        check("t1_rdv", 64'(last_out.rd_v), 64'hDEADBEEF);
        check("t1_valid", 64'(last_out.valid), 64'd1);
        step(nil, nil, nil, 0, 0);
        check("t1_once", 64'(last_out.valid), 64'd0);
        step(mk(0, 1), mk(1, 1), mk(2, 1), 0, 0);
        repeat (4) step(nil, nil, nil, 0, 0);
        repeat (20) step(mk(0, mq[0].size() < D - 1), mk(1, mq[1].size() < D - 1), nil, 0, 0);
        repeat (10) step(nil, nil, nil, 0, 0);
        repeat (7) step(mk(0, 1), mk(1, 1), mk(2, 1), 0, 0);
        repeat (3) step(nil, nil, nil, 0, 0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        repeat (12) step(nil, nil, nil, 0, 0);
        check("ovf_hold", 64'(overflow), 64'd1);
        repeat (4) step(mk(0, 1), mk(1, 1), mk(2, 1), 0, 0);
        step(mk(0, 1), nil, nil, 1, 0);
        check("flush_out", 64'(last_out.valid), 64'd0);
        step(nil, nil, nil, 0, 0);
        check("flush_stall", 64'({stall_div, stall_mul, stall_add}), 64'd0);
        repeat (400)
            step(mk(0, $urandom_range(0, 9) < 4), mk(1, $urandom_range(0, 9) < 4),
                 mk(2, $urandom_range(0, 9) < 4), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 99) == 0);
        repeat (5) step(mk(0, 1), mk(1, 1), mk(2, 1), 0, 0);
        step(nil, nil, nil, 0, 1);
        step(mk(0, 1), mk(1, 1), mk(2, 1), 0, 0);
        check("rst_ovf", 64'(overflow), 64'd0);
        step(nil, nil, nil, 0, 0);
        check("rst_add_first", 64'(last_out.rd_v[31:24]), 64'd0);
        repeat (4) step(nil, nil, nil, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
